// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: source indices and widths.
package cdb_arbiter_pkg;

    localparam int CDB_SRC_ALU  = 0;
    localparam int CDB_SRC_LSB  = 1;
    localparam int CDB_SRC_BR   = 2;
    localparam int CDB_NUM_SRC  = 3;

    // Same width as the ROB index used elsewhere in the core.
    localparam int CDB_ROB_ID_W = 5;
    localparam int CDB_DATA_W   = 32;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result queue of depth 2^FIFO_DEPTH_BIT; head is read combinationally.
module cdb_src_fifo #(
    parameter int WIDTH          = 37,
    parameter int FIFO_DEPTH_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BIT;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [FIFO_DEPTH_BIT-1:0] wr_ptr;
    logic [FIFO_DEPTH_BIT-1:0] rd_ptr;
    logic [FIFO_DEPTH_BIT:0]   count;

    // Pointer and occupancy tracking; a flush wins over any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Entry storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (FIFO_DEPTH_BIT+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that funnels queued producer results onto one registered CDB broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC        = CDB_NUM_SRC,
    parameter int FIFO_DEPTH_BIT = 1,
    parameter int ROB_ID_W       = CDB_ROB_ID_W,
    parameter int DATA_W         = CDB_DATA_W
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clear_flag,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*ROB_ID_W-1:0]  src_rob_id,
    input  logic [NUM_SRC*DATA_W-1:0]    src_val,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic                         cdb_valid,
    output logic [ROB_ID_W-1:0]          cdb_rob_id,
    output logic [DATA_W-1:0]            cdb_val,
    output logic [1:0]                   cdb_src
);

    localparam int ENTRY_W = ROB_ID_W + DATA_W;

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [ENTRY_W-1:0] head [NUM_SRC];
    logic [1:0]         rr_ptr;
    logic [1:0]         grant_idx;
    logic               grant_vld;

    // Modulo-NUM_SRC wrap for a search index that is at most 2*NUM_SRC-2.
    function automatic logic [1:0] wrap_src(input logic [2:0] s);
        if (s >= 3'(NUM_SRC)) return 2'(s - 3'(NUM_SRC));
        return s[1:0];
    endfunction

    // Ready reflects registered occupancy only, and is forced low while reset is held.
    assign src_ready = {NUM_SRC{rdy_in & ~rst_in}} & ~full;
    assign push      = src_valid & src_ready & {NUM_SRC{~clear_flag}};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_src_fifo #(
            .WIDTH          (ENTRY_W),
            .FIFO_DEPTH_BIT (FIFO_DEPTH_BIT)
        ) u_fifo (
            .clk       (clk_in),
            .rst       (rst_in),
            .clear     (clear_flag),
            .push      (push[i]),
            .pop       (pop[i]),
            .push_data ({src_rob_id[i*ROB_ID_W +: ROB_ID_W], src_val[i*DATA_W +: DATA_W]}),
            .head      (head[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    // Round-robin search starting at rr_ptr; the first non-empty queue wins.
    always_comb begin
        logic [1:0] cand;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = wrap_src({1'b0, rr_ptr} + 3'(k));
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Pop the granted head only when the broadcast register will actually take it.
    always_comb begin
        pop = '0;
        if (grant_vld && rdy_in && !clear_flag) pop[grant_idx] = 1'b1;
    end

    // --- grant -> broadcast register boundary ---
    // Broadcast register and round-robin pointer; flush beats stall, stall freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr     <= 2'(CDB_SRC_ALU);
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_val    <= '0;
            cdb_src    <= 2'(CDB_SRC_ALU);
        end else if (clear_flag) begin
            rr_ptr    <= 2'(CDB_SRC_ALU);
            cdb_valid <= 1'b0;
        end else if (rdy_in) begin
            if (grant_vld) begin
                rr_ptr     <= wrap_src({1'b0, grant_idx} + 3'd1);
                cdb_valid  <= 1'b1;
                cdb_rob_id <= head[grant_idx][ENTRY_W-1 -: ROB_ID_W];
                cdb_val    <= head[grant_idx][DATA_W-1:0];
                cdb_src    <= grant_idx;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, contention, backpressure, flush, stall, async reset.
module tb_cdb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_flag;
    logic [2:0]  src_valid;
    logic [14:0] src_rob_id;
    logic [95:0] src_val;
    logic [2:0]  src_ready;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_val;
    logic [1:0]  cdb_src;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear_flag (clear_flag),
        .src_valid  (src_valid),
        .src_rob_id (src_rob_id),
        .src_val    (src_val),
        .src_ready  (src_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_val    (cdb_val),
        .cdb_src    (cdb_src)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] val_of(input logic [4:0] id);
        return 32'hA500_0000 | 32'(id);
    endfunction

    // Present pushes; value is derived from the id so it can be predicted.
    task automatic drive(input logic [2:0] v, input logic [4:0] i0, input logic [4:0] i1, input logic [4:0] i2);
        src_valid  = v;
        src_rob_id = {i2, i1, i0};
        src_val    = {val_of(i2), val_of(i1), val_of(i0)};
    endtask

    task automatic idle_in();
        drive(3'b000, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic exp_bus(input string tag, input logic [1:0] src, input logic [4:0] id, input logic [31:0] val);
        chk({tag, ".bus"}, {cdb_valid, cdb_src, cdb_rob_id}, {1'b1, src, id});
        chk({tag, ".val"}, cdb_val, val);
    endtask

    task automatic do_reset();
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        clear_flag = 1'b0;
        idle_in();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        clear_flag = 1'b0;
        idle_in();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst.valid", cdb_valid, 0);
        chk("rst.outs", {cdb_src, cdb_rob_id, cdb_val}, 0);
        chk("rst.ready_held", src_ready, 3'b000);
        rst_in = 1'b0;
        #1;
        chk("rst.ready_rel", src_ready, 3'b111);

        // 1: single push, two-edge latency, one-cycle broadcast
        src_valid  = 3'b001;
        src_rob_id = {5'd0, 5'd0, 5'd5};
        src_val    = {32'h0, 32'h0, 32'hDEADBEEF};
        step();
        idle_in();
        chk("t1.edge1", cdb_valid, 0);
        step();
        exp_bus("t1.bcast", 2'd0, 5'd5, 32'hDEADBEEF);
        step();
        chk("t1.once", cdb_valid, 0);

        // 2: contention, round-robin order
        do_reset();
        drive(3'b111, 5'd1, 5'd2, 5'd3);
        step();
        drive(3'b111, 5'd4, 5'd5, 5'd6);
        chk("t2.none", cdb_valid, 0);
        step();
        idle_in();
        exp_bus("t2.b1", 2'd0, 5'd1, val_of(5'd1));
        step(); exp_bus("t2.b2", 2'd1, 5'd2, val_of(5'd2));
        step(); exp_bus("t2.b3", 2'd2, 5'd3, val_of(5'd3));
        step(); exp_bus("t2.b4", 2'd0, 5'd4, val_of(5'd4));
        step(); exp_bus("t2.b5", 2'd1, 5'd5, val_of(5'd5));
        step(); exp_bus("t2.b6", 2'd2, 5'd6, val_of(5'd6));
        step(); chk("t2.idle", cdb_valid, 0);
        // rr_ptr back at 0: a lone push on source 2 then source 0 together grants 0 first
        drive(3'b101, 5'd17, 5'd0, 5'd18);
        step(); idle_in();
        step(); exp_bus("t2.rr0", 2'd0, 5'd17, val_of(5'd17));
        step(); exp_bus("t2.rr2", 2'd2, 5'd18, val_of(5'd18));

        // 3: backpressure on source 1, source 0 pushing continuously
        do_reset();
        drive(3'b011, 5'd20, 5'd7, 5'd0);
        step();
        drive(3'b011, 5'd21, 5'd8, 5'd0);
        step();
        exp_bus("t3.b20", 2'd0, 5'd20, val_of(5'd20));
        chk("t3.rdy_full1", src_ready, 3'b101);
        drive(3'b011, 5'd22, 5'd9, 5'd0);
        step();
        idle_in();
        exp_bus("t3.b7", 2'd1, 5'd7, val_of(5'd7));
        chk("t3.rdy_full0", src_ready, 3'b110);
        step(); exp_bus("t3.b21", 2'd0, 5'd21, val_of(5'd21));
        step(); exp_bus("t3.b8", 2'd1, 5'd8, val_of(5'd8));
        step(); exp_bus("t3.b22", 2'd0, 5'd22, val_of(5'd22));
        step(); chk("t3.no9", cdb_valid, 0);
        step(); chk("t3.no9b", cdb_valid, 0);

        // 4: flush with four entries queued
        do_reset();
        drive(3'b111, 5'd11, 5'd12, 5'd13);
        step();
        drive(3'b110, 5'd0, 5'd14, 5'd15);
        step();
        exp_bus("t4.pre", 2'd0, 5'd11, val_of(5'd11));
        clear_flag = 1'b1;
        drive(3'b111, 5'd16, 5'd17, 5'd18);
        step();
        clear_flag = 1'b0;
        idle_in();
        chk("t4.valid", cdb_valid, 0);
        chk("t4.ready", src_ready, 3'b111);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4.quiet", cdb_valid, 0);
        end
        drive(3'b101, 5'd19, 5'd0, 5'd20);
        step(); idle_in();
        step(); exp_bus("t4.post0", 2'd0, 5'd19, val_of(5'd19));
        step(); exp_bus("t4.post2", 2'd2, 5'd20, val_of(5'd20));
        step(); chk("t4.end", cdb_valid, 0);

        // 5: stall while id 10 is on the bus
        do_reset();
        drive(3'b011, 5'd10, 5'd31, 5'd0);
        step(); idle_in();
        step();
        exp_bus("t5.b10", 2'd0, 5'd10, val_of(5'd10));
        rdy_in = 1'b0;
        #1;
        chk("t5.rdy_low", src_ready, 3'b000);
        for (int k = 0; k < 3; k++) begin
            step();
            exp_bus("t5.hold", 2'd0, 5'd10, val_of(5'd10));
        end
        rdy_in = 1'b1;
        step(); exp_bus("t5.b31", 2'd1, 5'd31, val_of(5'd31));
        step(); chk("t5.nodup", cdb_valid, 0);

        // 6: asynchronous reset between edges with work in flight
        do_reset();
        drive(3'b011, 5'd3, 5'd4, 5'd0);
        step(); idle_in();
        step();
        exp_bus("t6.pre", 2'd0, 5'd3, val_of(5'd3));
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6.async_valid", cdb_valid, 0);
        chk("t6.async_ready", src_ready, 3'b000);
        rst_in = 1'b0;
        #1;
        chk("t6.ready_rel", src_ready, 3'b111);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6.idle", cdb_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common-data-bus arbiter between the completion producers (ALU, LSB, branch unit) and the RS/ROB wakeup port.
- Each producer pushes (rob_id, value) results into a private 2-entry queue.
- The arbiter grants one queued result per cycle, round-robin, and drives a single registered broadcast.
- RS and ROB consume one broadcast per cycle, so simultaneous completions are never lost or double-written.

Parameters:
NUM_SRC, 3, number of producers (0 = ALU, 1 = LSB, 2 = branch).
FIFO_DEPTH_BIT, 1, log2 of per-source queue depth (depth 2).
ROB_ID_W, 5, ROB index width.
DATA_W, 32, result value width.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  asynchronous, active-high reset.
rdy_in  input  1  global ready; low freezes the block.
clear_flag  input  1  synchronous flush (branch mispredict).
src_valid  input  NUM_SRC  per-source push request.
src_rob_id  input  NUM_SRC*ROB_ID_W  packed ROB ids; source i occupies bits [i*ROB_ID_W +: ROB_ID_W].
src_val  input  NUM_SRC*DATA_W  packed result values, same packing rule.
src_ready  output  NUM_SRC  per-source queue not full.
cdb_valid  output  1  broadcast valid.
cdb_rob_id  output  ROB_ID_W  broadcast ROB id.
cdb_val  output  DATA_W  broadcast value.
cdb_src  output  2  index of the granted source.

Behaviour:
- Reset (asynchronous, rst_in high):
  - All queues empty; rr_ptr = 0.
  - cdb_valid = 0, cdb_rob_id = 0, cdb_val = 0, cdb_src = 0.
  - src_ready = all ones as soon as reset deasserts.
- src_ready[i] = rdy_in && count[i] < depth.
  - It is computed from the registered count only; a pop in the same cycle does not open a slot.
  - A push is accepted when src_valid[i] && src_ready[i] && !clear_flag.
  - A src_valid pulse while src_ready is low is dropped. Producers must hold or stall.
- Queue: FIFO order per source; pointers wrap modulo depth. Push and pop in the same cycle are both legal when 0 < count < depth.
- Arbitration, per cycle:
  - Candidates are the non-empty queues.
  - Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - The first candidate found is granted; its head is popped.
  - On grant to source g: rr_ptr <= (g+1) mod NUM_SRC. With no candidate, rr_ptr is unchanged.
- Output register, at the clock edge ending an arbitration cycle:
  - With a grant: cdb_valid <= 1 and the granted head's rob_id/val/index are loaded.
  - Without a grant: cdb_valid <= 0; cdb_rob_id, cdb_val and cdb_src keep their old values.
- Latency: a push accepted at edge k is granted in cycle k..k+1 and broadcast (cdb_valid high) in the cycle after edge k+1. Minimum is 2 edges from push presentation to broadcast.
- The same cycle's push cannot be granted; there is no bypass.
- clear_flag (synchronous, rdy_in-independent, priority over push/pop):
  - All queues are emptied and cdb_valid <= 0.
  - rr_ptr <= 0.
- rdy_in low, clear_flag low:
  - No push, no pop; rr_ptr and queues are held.
  - cdb_valid and the other outputs are held unchanged. Consumers also stall on rdy_in, so no duplicate is consumed.
- rst_in mid-operation: immediate asynchronous clear of all state. In-flight results are discarded.
- A broadcast lasts exactly one cycle per result. Each accepted result is broadcast exactly once unless flushed.

Decomposition:
- Shared definitions belong in const.v: CDB_SRC_ALU = 0, CDB_SRC_LSB = 1, CDB_SRC_BR = 2, CDB_NUM_SRC, and ROB_ID_W (reuse the existing ROB width define).
- One sub-module, cdb_src_fifo: a parameterised depth-2^FIFO_DEPTH_BIT queue.
  - Signals: push, pop, head data, count/full/empty.
  - Uses the same asynchronous reset and clear_flag.
  - Instantiated NUM_SRC times via generate.
- Arbiter and output register live in cdb_arbiter.

Test Plan:
1. Single push: after reset, src_valid = 001 with rob_id 5, val 0xDEADBEEF for one cycle → cdb_valid high exactly one cycle, 2 edges later, with rob_id = 5, val = 0xDEADBEEF, src = 0.
2. Contention: all three sources push in the same cycle (ids 1, 2, 3), then push again next cycle (ids 4, 5, 6) → broadcasts are ids 1, 2, 3, 4, 5, 6 on consecutive cycles with src 0, 1, 2, 0, 1, 2; rr_ptr returns to 0.
3. Backpressure: hold rdy_in high and push source 1 for three consecutive cycles (ids 7, 8, 9) while source 0 also pushes continuously.
   - src_ready[1] deasserts once count = 2.
   - The dropped id 9 is never broadcast.
   - ids 7 and 8 are broadcast in order, interleaved with source 0.
4. Flush: fill queues with 4 entries, assert clear_flag for one cycle (also asserting src_valid) → cdb_valid = 0 next cycle, no further broadcasts, src_ready = 111; a later push broadcasts normally with grant from source 0 first.
5. Stall: a broadcast of id 10 is on the bus when rdy_in drops for 3 cycles → cdb_valid/id 10 are held, no pops, src_ready = 000; after rdy_in rises, the next queued id follows with no loss or duplicate.
6. Async reset: assert rst_in between clock edges with queues non-empty → cdb_valid = 0 and src_ready = 000 immediately, without waiting for a clock edge; after release src_ready = 111 and the empty bus stays idle.
